div_stall_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider living in the EX stage; executes DIV/DIVU.
- It is the requesting side of the stall protocol. It raises a stall request toward the pipeline controller while a division is in flight, which freezes PC/IF/ID and holds the divide instruction in EX.
- It drops the request in the cycle its results are valid, so the pipeline advances with a correct HI/LO result.

---
 rtl/div_stall_unit_if.sv | 29 ++
 rtl/div_stall_unit.sv | 160 ++++++++++++++++
 tb/tb_div_stall_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/div_stall_unit_if.sv
// Handshake bundle between the EX-stage divide decode (master) and the
// multi-cycle divider (slave), including the stall request back to the
// pipeline controller.
interface div_stall_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  is_signed;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  flush;
    logic                  stall_request;
    logic                  done;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  div_by_zero;

    // EX decode / pipeline side
    modport master (
        output start, is_signed, dividend, divisor, flush,
        input  stall_request, done, quotient, remainder, div_by_zero
    );

    // Divider side
    modport slave (
        input  start, is_signed, dividend, divisor, flush,
        output stall_request, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_stall_unit.sv
// Radix-2 restoring divider for DIV/DIVU in EX. Holds the pipeline via
// stall_request while a division is in flight and releases it in the cycle
// the registered HI/LO results are presented together with a done pulse.
module div_stall_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,   // asynchronous, active-low
    div_stall_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;          // partial remainder
    logic [DATA_WIDTH-1:0] quo_q, quo_d;          // dividend shifting out / quotient shifting in
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;          // divisor magnitude
    logic [CNT_W-1:0]      cnt_q, cnt_d;          // iterations left
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  done_q, done_d;
    logic                  dbz_q, dbz_d;
    logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
    logic [DATA_WIDTH-1:0] remainder_q, remainder_d;

    logic [DATA_WIDTH-1:0] dividend_mag;
    logic [DATA_WIDTH-1:0] divisor_mag;
    logic [DATA_WIDTH:0]   rem_shift;
    logic                  rem_ge;
    logic [DATA_WIDTH-1:0] rem_step;
    logic [DATA_WIDTH-1:0] quo_step;

    // Operand magnitudes and one restoring-division iteration
    always_comb begin
        dividend_mag = (bus.is_signed && bus.dividend[DATA_WIDTH-1]) ? -bus.dividend : bus.dividend;
        divisor_mag  = (bus.is_signed && bus.divisor[DATA_WIDTH-1])  ? -bus.divisor  : bus.divisor;
        // The shifted remainder needs one extra bit: with a divisor above
        // 2^(DATA_WIDTH-1) it can exceed DATA_WIDTH bits before the compare.
        rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs_q});
        // The true difference is below dvs_q, so modulo-2^DATA_WIDTH is exact.
        rem_step  = rem_ge ? (rem_shift[DATA_WIDTH-1:0] - dvs_q) : rem_shift[DATA_WIDTH-1:0];
        quo_step  = {quo_q[DATA_WIDTH-2:0], rem_ge};
    end

    // FSM next-state and datapath next values; flush overrides everything
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        done_d      = 1'b0;
        dbz_d       = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    quo_d     = dividend_mag;
                    dvs_d     = divisor_mag;
                    rem_d     = '0;
                    cnt_d     = CNT_W'(DATA_WIDTH);
                    neg_quo_d = bus.is_signed & (bus.dividend[DATA_WIDTH-1] ^ bus.divisor[DATA_WIDTH-1]);
                    neg_rem_d = bus.is_signed & bus.dividend[DATA_WIDTH-1];
                    if (bus.divisor == '0) begin
                        // Divide by zero skips the iterations entirely and
                        // reports the raw dividend as the remainder.
                        state_d     = DONE;
                        done_d      = 1'b1;
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    quotient_d  = neg_quo_q ? -quo_step : quo_step;
                    remainder_d = neg_rem_q ? -rem_step : rem_step;
                end
            end
            DONE: begin
                // A start seen here belongs to the instruction now leaving
                // EX; the next divide is accepted from IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.flush) begin
            state_d     = IDLE;
            done_d      = 1'b0;
            dbz_d       = 1'b0;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    // Stall is combinational so the accept cycle itself already freezes
    // the front end; it is forced low while reset is held.
    assign bus.stall_request = rst & ~bus.flush &
                               (((state_q == IDLE) & bus.start) | (state_q == BUSY));
    assign bus.done          = done_q & ~bus.flush;
    assign bus.div_by_zero   = dbz_q & ~bus.flush;
    assign bus.quotient      = quotient_q;
    assign bus.remainder     = remainder_q;

endmodule

// File: tb/tb_div_stall_unit.sv
// Directed bench for div_stall_unit: timing of the stall window, signed and
// unsigned results, divide by zero, back-to-back issue, flush and reset.
module tb_div_stall_unit;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_stall_unit_if #(.DATA_WIDTH(W)) bus ();

    div_stall_unit #(.DATA_WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one divide starting at the current drive point (cycle 0) and
    // follows it until done; returns at the drive point of the next cycle
    // with start still high. done_cyc stays -1 if done never arrives.
    task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int stalls, output int done_cyc, output logic stall0,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        stalls   = 0;
        done_cyc = -1;
        stall0   = 1'b0;
        q        = '0;
        r        = '0;
        dbz      = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (cyc == 0) stall0 = bus.stall_request;
            if (bus.stall_request) stalls++;
            if (bus.done) begin
                done_cyc = cyc;
                q        = bus.quotient;
                r        = bus.remainder;
                dbz      = bus.div_by_zero;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd5;
        bus.divisor   = 32'd1;
        bus.flush     = 1'b0;
        #12;
        checks++; if (bus.stall_request !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", bus.stall_request); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b want=0", bus.div_by_zero); end
        checks++; if (bus.quotient !== 32'h0) begin errors++; $display("FAIL reset_quotient got=%h want=0", bus.quotient); end
        checks++; if (bus.remainder !== 32'h0) begin errors++; $display("FAIL reset_remainder got=%h want=0", bus.remainder); end
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int stalls, dc; logic s0, dbz; logic [W-1:0] q, r;
        do_div(1'b0, 32'd100, 32'd7, stalls, dc, s0, q, r, dbz);
        bus.start = 1'b0;
        checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL udiv_stall_cycle0 got=%b want=1", s0); end
        checks++; if (stalls !== 33) begin errors++; $display("FAIL udiv_stall_count got=%0d want=33", stalls); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL udiv_done_cycle got=%0d want=33", dc); end
        checks++; if (q !== 32'd14) begin errors++; $display("FAIL udiv_quotient got=%h want=%h", q, 32'd14); end
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL udiv_remainder got=%h want=%h", r, 32'd2); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL udiv_dbz got=%b want=0", dbz); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL udiv_done_one_cycle got=%b want=0", bus.done); end
        checks++; if (bus.quotient !== 32'd14) begin errors++; $display("FAIL udiv_quotient_hold got=%h want=%h", bus.quotient, 32'd14); end
        @(posedge clk); #1;
        // Divisor above 2^31 exercises the extra remainder bit.
        do_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, stalls, dc, s0, q, r, dbz);
        bus.start = 1'b0;
        checks++; if (q !== 32'd1) begin errors++; $display("FAIL udiv_big_quotient got=%h want=%h", q, 32'd1); end
        checks++; if (r !== 32'h7FFF_FFFE) begin errors++; $display("FAIL udiv_big_remainder got=%h want=%h", r, 32'h7FFF_FFFE); end
        @(posedge clk); #1;
    endtask

    task automatic test_signed();
        int stalls, dc; logic s0, dbz; logic [W-1:0] q, r;
        do_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, stalls, dc, s0, q, r, dbz);
        bus.start = 1'b0;
        checks++; if (stalls !== 33) begin errors++; $display("FAIL sdiv_stall_count got=%0d want=33", stalls); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL sdiv_done_cycle got=%0d want=33", dc); end
        checks++; if (q !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_quotient got=%h want=%h", q, 32'hFFFF_FFFD); end
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_remainder got=%h want=%h", r, 32'hFFFF_FFFF); end
        @(posedge clk); #1;
        // 7 / -2 = -3 remainder 1
        do_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, stalls, dc, s0, q, r, dbz);
        bus.start = 1'b0;
        checks++; if (q !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_negdvs_quotient got=%h want=%h", q, 32'hFFFF_FFFD); end
        checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL sdiv_negdvs_remainder got=%h want=%h", r, 32'h1); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_by_zero();
        int stalls, dc; logic s0, dbz; logic [W-1:0] q, r;
        do_div(1'b1, 32'h1234_5678, 32'h0, stalls, dc, s0, q, r, dbz);
        bus.start = 1'b0;
        checks++; if (stalls !== 1) begin errors++; $display("FAIL dbz_stall_count got=%0d want=1", stalls); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL dbz_done_cycle got=%0d want=1", dc); end
        checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dbz_flag got=%b want=1", dbz); end
        checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_quotient got=%h want=%h", q, 32'hFFFF_FFFF); end
        checks++; if (r !== 32'h1234_5678) begin errors++; $display("FAIL dbz_remainder got=%h want=%h", r, 32'h1234_5678); end
        @(negedge clk);
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_flag_clear got=%b want=0", bus.div_by_zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int stalls, dc; logic s0, dbz; logic [W-1:0] q, r;
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, stalls, dc, s0, q, r, dbz);
        checks++; if (dc !== 33) begin errors++; $display("FAIL b2b_first_done_cycle got=%0d want=33", dc); end
        checks++; if (q !== 32'h8000_0000) begin errors++; $display("FAIL b2b_first_quotient got=%h want=%h", q, 32'h8000_0000); end
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL b2b_first_remainder got=%h want=0", r); end
        // start stays high: the next divide enters EX right after DONE.
        do_div(1'b0, 32'd9, 32'd3, stalls, dc, s0, q, r, dbz);
        bus.start = 1'b0;
        checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble got=%b want=1", s0); end
        checks++; if (stalls !== 33) begin errors++; $display("FAIL b2b_second_stall_count got=%0d want=33", stalls); end
        checks++; if (q !== 32'd3) begin errors++; $display("FAIL b2b_second_quotient got=%h want=%h", q, 32'd3); end
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL b2b_second_remainder got=%h want=0", r); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int done_seen;
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        checks++; if (bus.stall_request !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b want=0", bus.stall_request); end
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checks++; if (bus.stall_request !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got=%b want=0", bus.stall_request); end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL flush_no_done got=%0d want=0", done_seen); end
        checks++; if (bus.quotient !== 32'd3) begin errors++; $display("FAIL flush_quotient_kept got=%h want=%h", bus.quotient, 32'd3); end
        checks++; if (bus.remainder !== 32'd0) begin errors++; $display("FAIL flush_remainder_kept got=%h want=0", bus.remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int stalls, dc; logic s0, dbz; logic [W-1:0] q, r;
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd12345;
        bus.divisor   = 32'd100;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.stall_request !== 1'b0) begin errors++; $display("FAIL arst_stall got=%b want=0", bus.stall_request); end
        checks++; if (bus.quotient !== 32'h0) begin errors++; $display("FAIL arst_quotient got=%h want=0", bus.quotient); end
        checks++; if (bus.remainder !== 32'h0) begin errors++; $display("FAIL arst_remainder got=%h want=0", bus.remainder); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL arst_done got=%b want=0", bus.done); end
        @(posedge clk); #1;
        rst = 1'b1;
        do_div(1'b0, 32'd12345, 32'd100, stalls, dc, s0, q, r, dbz);
        bus.start = 1'b0;
        checks++; if (stalls !== 33) begin errors++; $display("FAIL arst_rerun_stalls got=%0d want=33", stalls); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL arst_rerun_done_cycle got=%0d want=33", dc); end
        checks++; if (q !== 32'd123) begin errors++; $display("FAIL arst_rerun_quotient got=%h want=%h", q, 32'd123); end
        checks++; if (r !== 32'd45) begin errors++; $display("FAIL arst_rerun_remainder got=%h want=%h", r, 32'd45); end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
